// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and
// the width of the read-latency counter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {REQ_CPU, REQ_IO} requester_e;

  // Counter sized for the largest legal BRAM read latency (3).
  localparam int READ_LAT_MAX = 3;
  localparam int LAT_W        = $clog2(READ_LAT_MAX + 1);

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is the CPU, bit 1 is the IO loader.
// On a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt_onehot
);

  // Starts as "IO granted last" so the CPU wins the first tie.
  logic last_io;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_io <= 1'b1;
    end else if (update && (gnt_onehot != 2'b00)) begin
      last_io <= gnt_onehot[1];
    end
  end

  always_comb begin
    gnt_onehot = 2'b00;
    if (req == 2'b11) begin
      gnt_onehot = last_io ? 2'b01 : 2'b10;
    end else begin
      gnt_onehot = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data BRAM between the CPU load/store path and the
// UART loader. One access in flight; read latency hidden behind gnt/rvalid.
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it sees
// a one-cycle gnt; a read then returns a one-cycle rvalid with rdata.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BRAM_SIZE = 18,
  parameter int READ_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [31:0]          cpu_rdata,
  input  logic                 io_req,
  input  logic                 io_we,
  input  logic [31:0]          io_addr,
  input  logic [31:0]          io_wdata,
  output logic                 io_gnt,
  output logic                 io_rvalid,
  output logic [31:0]          io_rdata,
  output logic [BRAM_SIZE-1:0] bram_addr,
  output logic [31:0]          bram_din,
  output logic                 bram_we,
  input  logic [31:0]          bram_dout,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  state_e               state, next_state;
  requester_e           win_q;
  logic                 lat_we;
  logic [BRAM_SIZE-1:0] lat_addr;
  logic [31:0]          lat_din;
  logic [LAT_W-1:0]     lat_cnt;
  logic [1:0]           arb_gnt;
  logic                 any_req;
  logic                 pick_io;
  logic                 capture;
  logic [31:0]          sel_addr;

  // Byte-offset bits and anything above the BRAM depth are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:BRAM_SIZE+2],
                              io_addr[1:0], io_addr[31:BRAM_SIZE+2]};

  assign any_req  = cpu_req | io_req;
  assign pick_io  = arb_gnt[1];
  assign sel_addr = pick_io ? io_addr : cpu_addr;

  rr_arb2 u_rr_arb2 (
    .clk        (clk),
    .rstn       (rstn),
    .req        ({io_req, cpu_req}),
    .update     ((state == IDLE) && any_req),
    .gnt_onehot (arb_gnt)
  );

  // Read data is taken on the last cycle before RESP; with READ_LAT=1 that is ISSUE.
  always_comb begin
    capture = 1'b0;
    if (state == ISSUE && !lat_we && READ_LAT == 1) capture = 1'b1;
    if (state == WAIT && lat_cnt == LAT_W'(1))      capture = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      win_q     <= REQ_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_din   <= '0;
      lat_cnt   <= '0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && any_req) begin
        win_q    <= pick_io ? REQ_IO : REQ_CPU;
        lat_we   <= pick_io ? io_we : cpu_we;
        lat_addr <= sel_addr[BRAM_SIZE+1:2];
        lat_din  <= pick_io ? io_wdata : cpu_wdata;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(READ_LAT - 1);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (capture) begin
        if (win_q == REQ_IO) io_rdata  <= bram_dout;
        else                 cpu_rdata <= bram_dout;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (any_req) next_state = ISSUE;
      ISSUE: begin
        if (lat_we)             next_state = IDLE;
        else if (READ_LAT == 1) next_state = RESP;
        else                    next_state = WAIT;
      end
      WAIT:  if (lat_cnt == LAT_W'(1)) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    bram_addr  = lat_addr;
    bram_din   = lat_din;
    bram_we    = (state == ISSUE) && lat_we;
    cpu_gnt    = (state == ISSUE) && (win_q == REQ_CPU);
    io_gnt     = (state == ISSUE) && (win_q == REQ_IO);
    cpu_rvalid = (state == RESP)  && (win_q == REQ_CPU);
    io_rvalid  = (state == RESP)  && (win_q == REQ_IO);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 2-cycle-latency BRAM.
module tb_dmem_arbiter;

  localparam int BRAM_SIZE = 18;
  localparam int READ_LAT  = 2;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 cpu_req, cpu_we, io_req, io_we;
  logic [31:0]          cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic                 cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
  logic [31:0]          cpu_rdata, io_rdata;
  logic [BRAM_SIZE-1:0] bram_addr;
  logic [31:0]          bram_din, bram_dout;
  logic                 bram_we, busy;
  logic [1:0]           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.BRAM_SIZE(BRAM_SIZE), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout), .busy(busy), .dbg_state(dbg_state)
  );

  // BRAM model: address sampled at an edge, data visible one cycle later,
  // so data reaches the arbiter's capture register READ_LAT cycles after issue.
  logic [31:0] mem [0:255];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr[7:0]] <= bram_din;
    rd_q <= mem[bram_addr[7:0]];
  end
  assign bram_dout = rd_q;

  logic unused_tb;
  assign unused_tb = ^{bram_addr[BRAM_SIZE-1:8], dbg_state};

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      n_cmp++;
      if ((cpu_gnt && io_gnt) || (bram_we && !(cpu_gnt || io_gnt))) begin
        n_bad++;
        $display("FAIL invariant: cpu_gnt=%b io_gnt=%b bram_we=%b", cpu_gnt, io_gnt, bram_we);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit is_io, input bit we, input logic [31:0] addr,
                           input logic [31:0] data);
    if (is_io) begin
      io_req = 1'b1; io_we = we; io_addr = addr; io_wdata = data;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
  endtask

  task automatic wait_gnt(input bit is_io, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (is_io ? io_gnt : cpu_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rvalid(input bit is_io, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (is_io ? io_rvalid : cpu_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Full access: request, wait for grant, release, and for reads wait for rvalid.
  task automatic xfer(input bit is_io, input bit we, input logic [31:0] addr,
                      input logic [31:0] data, output bit ok, output logic [31:0] rdata);
    bit g, r;
    drive_req(is_io, we, addr, data);
    wait_gnt(is_io, g);
    if (is_io) io_req = 1'b0; else cpu_req = 1'b0;
    r = 1'b1;
    rdata = '0;
    if (g && !we) begin
      wait_rvalid(is_io, r);
      rdata = is_io ? io_rdata : cpu_rdata;
    end
    ok = g && r;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_req(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678);
    drive_req(1'b1, 1'b1, 32'h0000_0020, 32'h8765_4321);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, bram_we, busy} !== 6'b0 ||
          bram_addr !== '0 || bram_din !== 32'h0 || cpu_rdata !== 32'h0 || io_rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL reset cycle %0d: ctl=%b addr=%h din=%h crd=%h ird=%h required all zero",
                 i, {cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, bram_we, busy},
                 bram_addr, bram_din, cpu_rdata, io_rdata);
      end
    end
    cpu_req = 1'b0; io_req = 1'b0; cpu_we = 1'b0; io_we = 1'b0;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    bit ok;
    drive_req(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    n_cmp++;
    if (cpu_gnt !== 1'b1 || io_gnt !== 1'b0 || bram_we !== 1'b1 || bram_addr !== 18'd4 ||
        bram_din !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL write_issue: gnt=%b we=%b addr=%h din=%h required 1 1 4 deadbeef",
               cpu_gnt, bram_we, bram_addr, bram_din);
    end
    cpu_req = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b0 || bram_we !== 1'b0 || mem[4] !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL write_done: busy=%b we=%b mem4=%h required 0 0 deadbeef", busy, bram_we, mem[4]);
    end
    drive_req(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    step();
    n_cmp++;
    if (cpu_gnt !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 18'd4) begin
      n_bad++;
      $display("FAIL read_issue: gnt=%b we=%b addr=%h required 1 0 4", cpu_gnt, bram_we, bram_addr);
    end
    cpu_req = 1'b0;
    step();
    n_cmp++;
    if (busy !== 1'b1 || cpu_rvalid !== 1'b0 || bram_addr !== 18'd4) begin
      n_bad++;
      $display("FAIL read_wait: busy=%b rvalid=%b addr=%h required 1 0 4", busy, cpu_rvalid, bram_addr);
    end
    step();
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || io_rvalid !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL read_resp: rvalid=%b io_rvalid=%b rdata=%h required 1 0 deadbeef",
               cpu_rvalid, io_rvalid, cpu_rdata);
    end
    step();
    ok = (cpu_rvalid === 1'b0 && busy === 1'b0);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL read_end: rvalid=%b busy=%b required 0 0", cpu_rvalid, busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok, got, exp_io;
    logic [31:0] rd;
    xfer(1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, ok, rd);
    xfer(1'b1, 1'b1, 32'h0000_0040, 32'h3333_4444, ok, rd);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rr_setup: io write timed out, required grant");
    end
    drive_req(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    drive_req(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp_io = (k % 2) == 1;
      got = 1'b0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (cpu_gnt || io_gnt) begin
          got = 1'b1;
          break;
        end
      end
      n_cmp++;
      if (!got || io_gnt !== exp_io || cpu_gnt !== !exp_io) begin
        n_bad++;
        $display("FAIL rr_order %0d: cpu_gnt=%b io_gnt=%b required io=%b", k, cpu_gnt, io_gnt, exp_io);
      end
      step();
      step();
      n_cmp++;
      if (cpu_rvalid !== !exp_io || io_rvalid !== exp_io) begin
        n_bad++;
        $display("FAIL rr_rvalid %0d: cpu_rvalid=%b io_rvalid=%b required io=%b",
                 k, cpu_rvalid, io_rvalid, exp_io);
      end
      rd = exp_io ? io_rdata : cpu_rdata;
      n_cmp++;
      if (rd !== (exp_io ? 32'h3333_4444 : 32'h1111_2222)) begin
        n_bad++;
        $display("FAIL rr_rdata %0d: got %h required %h", k, rd,
                 exp_io ? 32'h3333_4444 : 32'h1111_2222);
      end
      if (k == 3) begin
        cpu_req = 1'b0;
        io_req = 1'b0;
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    bit ok;
    addrs[0] = 32'h0000_0013;
    addrs[1] = 32'h0100_0010;
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b0, 1'b0, addrs[k], 32'h0);
      wait_gnt(1'b0, ok);
      cpu_req = 1'b0;
      n_cmp++;
      if (!ok || bram_addr !== 18'd4) begin
        n_bad++;
        $display("FAIL misaligned_addr %h: gnt_ok=%b bram_addr=%h required 4", addrs[k], ok, bram_addr);
      end
      wait_rvalid(1'b0, ok);
      n_cmp++;
      if (!ok || cpu_rdata !== 32'hDEAD_BEEF) begin
        n_bad++;
        $display("FAIL misaligned_data %h: ok=%b rdata=%h required deadbeef", addrs[k], ok, cpu_rdata);
      end
    end
  endtask

  task automatic test_io_during_wait();
    bit ok;
    logic [31:0] rd;
    drive_req(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    wait_gnt(1'b0, ok);
    cpu_req = 1'b0;
    step();
    drive_req(1'b1, 1'b1, 32'h0000_0044, 32'h5555_AAAA);
    n_cmp++;
    if (!ok || io_gnt !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_wait: gnt_ok=%b io_gnt=%b busy=%b required 1 0 1", ok, io_gnt, busy);
    end
    step();
    n_cmp++;
    if (cpu_rvalid !== 1'b1 || io_gnt !== 1'b0 || cpu_rdata !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL overlap_resp: rvalid=%b io_gnt=%b rdata=%h required 1 0 11112222",
               cpu_rvalid, io_gnt, cpu_rdata);
    end
    step();
    n_cmp++;
    if (io_gnt !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap_idle: io_gnt=%b busy=%b required 0 0", io_gnt, busy);
    end
    step();
    n_cmp++;
    if (io_gnt !== 1'b1 || bram_we !== 1'b1 || bram_addr !== 18'h11 || bram_din !== 32'h5555_AAAA) begin
      n_bad++;
      $display("FAIL overlap_issue: io_gnt=%b we=%b addr=%h din=%h required 1 1 11 5555aaaa",
               io_gnt, bram_we, bram_addr, bram_din);
    end
    io_req = 1'b0;
    xfer(1'b1, 1'b0, 32'h0000_0044, 32'h0, ok, rd);
    n_cmp++;
    if (!ok || rd !== 32'h5555_AAAA || cpu_rdata !== 32'h1111_2222) begin
      n_bad++;
      $display("FAIL overlap_readback: ok=%b io_rdata=%h cpu_rdata=%h required 1 5555aaaa 11112222",
               ok, rd, cpu_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int stray;
    logic [31:0] rd;
    drive_req(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    wait_gnt(1'b0, ok);
    cpu_req = 1'b0;
    step();
    rstn = 1'b0;
    step();
    n_cmp++;
    if (!ok || busy !== 1'b0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_reset: gnt_ok=%b busy=%b rvalid=%b rdata=%h required 1 0 0 0",
               ok, busy, cpu_rvalid, cpu_rdata);
    end
    rstn = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_rvalid || io_rvalid || busy) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL abort_stray: %0d cycles with rvalid/busy, required 0", stray);
    end
    xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, ok, rd);
    n_cmp++;
    if (!ok || rd !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL abort_recover: ok=%b rdata=%h required 1 deadbeef", ok, rd);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req = 1'b0; io_we = 1'b0; io_addr = '0; io_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_misaligned();
    test_io_during_wait();
    test_reset_in_wait();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
